// File: rtl/tilelink_ul_mem_slave.sv
// Single-outstanding TileLink-UL/UH slave over a word-addressed RAM, with multi-beat Get/Put bursts.
// Define TLMEM_ERR_EN to flag out-of-range addresses and oversize requests with d_error.
module tilelink_ul_mem_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          MEM_WORDS = 1024,
  parameter int          MAX_SIZE  = 6
) (
  input  logic        clock,
  input  logic        reset,
  output logic        a_ready,
  input  logic        a_valid,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [3:0]  a_size,
  input  logic        a_source,
  input  logic [31:0] a_address,
  input  logic [3:0]  a_mask,
  input  logic [31:0] a_data,
  input  logic        d_ready,
  output logic        d_valid,
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [3:0]  d_size,
  output logic        d_source,
  output logic        d_sink,
  output logic [1:0]  d_addr_lo,
  output logic [31:0] d_data,
  output logic        d_error
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = MAX_SIZE - 1;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_INTENT   = 3'd5;

  typedef enum logic [1:0] {IDLE, PUT_DATA, RESP} state_e;

  // Beat count is clamped at MAX_SIZE so an oversize request still terminates.
  function automatic logic [BW-1:0] beats_m1(input logic [3:0] sz);
    logic [3:0] s;
    s = (sz > 4'(MAX_SIZE)) ? 4'(MAX_SIZE) : sz;
    if (s <= 4'd2) return '0;
    return BW'((32'd1 << (s - 4'd2)) - 32'd1);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [3:0] sz,
                                            input logic [BW-1:0] k);
    logic [31:0] m;
    m = (32'd1 << sz) - 32'd1;
    return (a & ~m) | ((a + {{(30-BW){1'b0}}, k, 2'b00}) & m);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem [MEM_WORDS];

  state_e        state_q, state_d;
  logic [2:0]    op_opcode_q, op_opcode_d;
  logic [3:0]    op_size_q, op_size_d;
  logic          op_source_q, op_source_d;
  logic [31:0]   op_addr_q, op_addr_d;
  logic          op_err_q, op_err_d;
  logic [BW-1:0] beat_q, beat_d;

  logic          req_err, req_put, accept, d_last, wr_en;
  logic          op_is_put, op_is_get, op_is_hint;
  logic [AW-1:0] rd_idx, wr_idx;
  logic [31:0]   rd_data;
  logic          unused_a_param;

  assign unused_a_param = ^a_param;

`ifdef TLMEM_ERR_EN
  localparam logic [32:0] TOP_ADDR = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);
  assign req_err = ({1'b0, a_address} < {1'b0, BASE_ADDR}) || ({1'b0, a_address} >= TOP_ADDR) ||
                   (a_size > 4'(MAX_SIZE));
`else
  assign req_err = 1'b0;
`endif

  assign req_put    = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
  assign op_is_put  = (op_opcode_q == OP_PUT_FULL) || (op_opcode_q == OP_PUT_PART);
  assign op_is_get  = (op_opcode_q == OP_GET);
  assign op_is_hint = (op_opcode_q == OP_INTENT);
  assign d_last     = (op_is_put || op_is_hint) ? 1'b1 : (beat_q == beats_m1(op_size_q));
  assign rd_idx     = word_idx(beat_addr(op_addr_q, op_size_q, beat_q));
  assign rd_data    = mem[rd_idx];

  always_comb begin
    state_d     = state_q;
    op_opcode_d = op_opcode_q;
    op_size_d   = op_size_q;
    op_source_d = op_source_q;
    op_addr_d   = op_addr_q;
    op_err_d    = op_err_q;
    beat_d      = beat_q;
    a_ready     = 1'b0;
    d_valid     = 1'b0;
    d_opcode    = 3'd0;
    d_param     = 2'd0;
    d_size      = 4'd0;
    d_source    = 1'b0;
    d_sink      = 1'b0;
    d_addr_lo   = 2'd0;
    d_data      = 32'd0;
    d_error     = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = rd_idx;
    accept      = 1'b0;
    case (state_q)
      IDLE: accept = 1'b1;
      PUT_DATA: begin
        a_ready = 1'b1;
        if (a_valid) begin
          wr_en = !op_err_q;
          if (beat_q == beats_m1(op_size_q)) begin
            state_d = RESP;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      RESP: begin
        d_valid   = 1'b1;
        d_opcode  = op_is_put ? 3'd0 : (op_is_hint ? 3'd2 : 3'd1);
        d_size    = op_size_q;
        d_source  = op_source_q;
        d_addr_lo = op_addr_q[1:0];
        d_error   = op_err_q || !(op_is_get || op_is_put || op_is_hint);
        d_data    = (op_is_get && !op_err_q) ? rd_data : 32'd0;
        if (d_ready) begin
          if (d_last) begin
            state_d = IDLE;
            beat_d  = '0;
            accept  = 1'b1;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A new request can land in IDLE or on the final D handshake, with no bubble.
    if (accept) begin
      a_ready = 1'b1;
      if (a_valid) begin
        op_opcode_d = a_opcode;
        op_size_d   = a_size;
        op_source_d = a_source;
        op_addr_d   = a_address;
        op_err_d    = req_err;
        wr_en       = req_put && !req_err;
        wr_idx      = word_idx(a_address);
        if (req_put && (beats_m1(a_size) != '0)) begin
          state_d = PUT_DATA;
          beat_d  = BW'(1);
        end else begin
          state_d = RESP;
          beat_d  = '0;
        end
      end
    end
    if (reset) begin
      a_ready   = 1'b0;
      d_valid   = 1'b0;
      d_opcode  = 3'd0;
      d_size    = 4'd0;
      d_source  = 1'b0;
      d_addr_lo = 2'd0;
      d_data    = 32'd0;
      d_error   = 1'b0;
      wr_en     = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      op_opcode_q <= 3'd0;
      op_size_q   <= 4'd0;
      op_source_q <= 1'b0;
      op_addr_q   <= 32'd0;
      op_err_q    <= 1'b0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_opcode_q <= op_opcode_d;
      op_size_q   <= op_size_d;
      op_source_q <= op_source_d;
      op_addr_q   <= op_addr_d;
      op_err_q    <= op_err_d;
      beat_q      <= beat_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (a_mask[b]) mem[wr_idx][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_tilelink_ul_mem_slave.sv
// Directed bench for tilelink_ul_mem_slave: Get/Put singles and bursts, stalls, back-to-back, errors.
module tb_tilelink_ul_mem_slave;
  logic        clock = 1'b0;
  logic        reset;
  logic        a_ready, a_valid, a_source, d_ready, d_valid, d_source, d_sink, d_error;
  logic [2:0]  a_opcode, a_param, d_opcode;
  logic [3:0]  a_size, a_mask, d_size;
  logic [31:0] a_address, a_data, d_data;
  logic [1:0]  d_param, d_addr_lo;

  int checks = 0;
  int errors = 0;

  tilelink_ul_mem_slave dut (
    .clock(clock), .reset(reset),
    .a_ready(a_ready), .a_valid(a_valid), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_ready(d_ready), .d_valid(d_valid), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_addr_lo(d_addr_lo),
    .d_data(d_data), .d_error(d_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic a_beat(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] data);
    int n = 0;
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_address = addr; a_mask = mask; a_data = data;
    #1;
    while (!a_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("a_ready_wait", a_ready, 1);
    step();
    a_valid = 1'b0;
  endtask

  task automatic d_beat(input string tag, input logic [2:0] op, input logic [31:0] data,
                        input logic err, input logic [3:0] sz, input logic [1:0] lo);
    int n = 0;
    d_ready = 1'b1;
    #1;
    while (!d_valid && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_vld"}, d_valid, 1);
    chk({tag, "_op"}, d_opcode, op);
    chk({tag, "_data"}, d_data, data);
    chk({tag, "_err"}, d_error, err);
    chk({tag, "_size"}, d_size, sz);
    chk({tag, "_lo"}, d_addr_lo, lo);
    chk({tag, "_src"}, d_source, a_source);
    chk({tag, "_psk"}, {d_param, d_sink}, 0);
    step();
    d_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1; a_valid = 1'b0; a_opcode = 3'd0; a_param = 3'd0; a_size = 4'd0;
    a_source = 1'b0; a_address = 32'd0; a_mask = 4'd0; a_data = 32'd0; d_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_a_ready", a_ready, 0);
      chk("rst_d_valid", d_valid, 0);
    end
    reset = 1'b0;
    #1;
    chk("post_rst_a_ready", a_ready, 1);
    chk("post_rst_d_valid", d_valid, 0);

    // Single-beat write then read-back
    a_beat(3'd0, 4'd2, 32'h0001_0004, 4'hF, 32'hDEAD_BEEF);
    chk("put1_latency", d_valid, 1);
    d_beat("put1", 3'd0, 32'd0, 1'b0, 4'd2, 2'd0);
    a_beat(3'd4, 4'd2, 32'h0001_0004, 4'h0, 32'd0);
    d_beat("get1", 3'd1, 32'hDEAD_BEEF, 1'b0, 4'd2, 2'd0);

    // Partial write merges one byte lane
    a_source = 1'b1;
    a_beat(3'd0, 4'd2, 32'h0001_0008, 4'hF, 32'h1122_3344);
    d_beat("put2", 3'd0, 32'd0, 1'b0, 4'd2, 2'd0);
    a_beat(3'd1, 4'd2, 32'h0001_0008, 4'b0010, 32'h0000_AB00);
    d_beat("pput", 3'd0, 32'd0, 1'b0, 4'd2, 2'd0);
    a_beat(3'd4, 4'd2, 32'h0001_0008, 4'h0, 32'd0);
    d_beat("get2", 3'd1, 32'h1122_AB44, 1'b0, 4'd2, 2'd0);
    a_beat(3'd4, 4'd0, 32'h0001_000A, 4'h4, 32'd0);
    d_beat("get_byte", 3'd1, 32'h1122_AB44, 1'b0, 4'd0, 2'd2);
    a_source = 1'b0;

    // 4-beat Put burst gives exactly one ack
    for (int i = 0; i < 4; i++) begin
      a_beat(3'd0, 4'd4, 32'h0001_0020, 4'hF, 32'(i + 1));
      if (i < 3) chk("bput_no_d", d_valid, 0);
    end
    chk("bput_latency", d_valid, 1);
    d_beat("bput", 3'd0, 32'd0, 1'b0, 4'd4, 2'd0);
    #1;
    chk("bput_one_ack", d_valid, 0);

    // 4-beat Get with d_ready toggling; data held across stalls
    a_beat(3'd4, 4'd4, 32'h0001_0020, 4'h0, 32'd0);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      d_ready = (i % 2 == 1);
      #1;
      chk("bget_vld", d_valid, 1);
      chk("bget_data", d_data, 32'(k + 1));
      chk("bget_a_ready", a_ready, 32'(i == 7));
      if (d_ready) k++;
      step();
    end
    d_ready = 1'b0;
    #1;
    chk("bget_done", d_valid, 0);

    // Burst wraps inside its size-aligned window
    a_beat(3'd4, 4'd3, 32'h0001_0024, 4'h0, 32'd0);
    d_beat("wrap0", 3'd1, 32'd2, 1'b0, 4'd3, 2'd0);
    d_beat("wrap1", 3'd1, 32'd1, 1'b0, 4'd3, 2'd0);

    // New Get accepted on the final D handshake of the previous one
    a_beat(3'd4, 4'd2, 32'h0001_0004, 4'h0, 32'd0);
    d_ready = 1'b1;
    a_valid = 1'b1; a_opcode = 3'd4; a_size = 4'd2; a_address = 32'h0001_0020;
    #1;
    chk("nb_a_ready", a_ready, 1);
    chk("nb_d0", d_data, 32'hDEAD_BEEF);
    step();
    a_valid = 1'b0;
    chk("nb_d_valid", d_valid, 1);
    chk("nb_d1", d_data, 32'd1);
    step();
    d_ready = 1'b0;
    #1;
    chk("nb_idle", d_valid, 0);

    // Arithmetic: error data beats, RAM untouched
    a_beat(3'd2, 4'd3, 32'h0001_0020, 4'hF, 32'hFFFF_FFFF);
    d_beat("arith0", 3'd1, 32'd0, 1'b1, 4'd3, 2'd0);
    d_beat("arith1", 3'd1, 32'd0, 1'b1, 4'd3, 2'd0);
    a_beat(3'd4, 4'd2, 32'h0001_0020, 4'h0, 32'd0);
    d_beat("arith_ram", 3'd1, 32'd1, 1'b0, 4'd2, 2'd0);

    // Intent gives a single HintAck
    a_beat(3'd5, 4'd3, 32'h0001_0020, 4'h0, 32'd0);
    d_beat("hint", 3'd2, 32'd0, 1'b0, 4'd3, 2'd0);
    #1;
    chk("hint_one", d_valid, 0);

    // Unknown opcode
    a_beat(3'd6, 4'd2, 32'h0001_0020, 4'hF, 32'd0);
    d_beat("bad_op", 3'd1, 32'd0, 1'b1, 4'd2, 2'd0);

    // Reset mid-burst drops the transaction but keeps the first write
    a_beat(3'd0, 4'd4, 32'h0001_0040, 4'hF, 32'hA5A5_A5A5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("mid_rst_a_ready", a_ready, 1);
    chk("mid_rst_d_valid", d_valid, 0);
    a_beat(3'd4, 4'd2, 32'h0001_0040, 4'hF, 32'd0);
    d_beat("rst_keep", 3'd1, 32'hA5A5_A5A5, 1'b0, 4'd2, 2'd0);

`ifdef TLMEM_ERR_EN
    a_beat(3'd0, 4'd2, 32'h0001_0000, 4'hF, 32'h1234_5678);
    d_beat("err_pre", 3'd0, 32'd0, 1'b0, 4'd2, 2'd0);
    a_beat(3'd4, 4'd3, 32'h0000_0000, 4'h0, 32'd0);
    d_beat("err_get0", 3'd1, 32'd0, 1'b1, 4'd3, 2'd0);
    d_beat("err_get1", 3'd1, 32'd0, 1'b1, 4'd3, 2'd0);
    a_beat(3'd0, 4'd2, 32'h0000_0000, 4'hF, 32'd5);
    d_beat("err_put", 3'd0, 32'd0, 1'b1, 4'd2, 2'd0);
    a_beat(3'd4, 4'd2, 32'h0001_0000, 4'h0, 32'd0);
    d_beat("err_ram", 3'd1, 32'h1234_5678, 1'b0, 4'd2, 2'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
